lcd_sequencer: RTL and testbench
================================

LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 SHALL have parameter COLS, default 16, the number of characters per LCD line.
REQ-002 SHALL have parameter POWERUP_STEPS, default 20, the number of step events to wait after reset before initialisation.
REQ-003 SHALL have port clk, input, 1 bit: the FPGA system clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port tick_in, input, 1 bit: slow pacing toggle from the upstream clock divider (the 50 Hz state counter).
REQ-006 SHALL have port wr_valid, input, 1 bit: a write request is present.
REQ-007 SHALL have port wr_rs, input, 1 bit: 1 = character data, 0 = LCD command.
REQ-008 SHALL have port wr_data, input, 8 bits: the byte to write.
REQ-009 SHALL have port wr_ready, output, 1 bit: the block can accept a request this cycle.
REQ-010 SHALL have port busy, output, 1 bit: the block is not in READY.
REQ-011 SHALL have port lcd_rs, output, 1 bit: LCD register select.
REQ-012 SHALL have port lcd_rw, output, 1 bit: LCD read/write select; tied to 0 (write only).
REQ-013 SHALL have port lcd_e, output, 1 bit: LCD enable strobe.
REQ-014 SHALL have port lcd_data, output, 8 bits: LCD data bus.

Function
REQ-015 SHALL register tick_in every clk; a step event occurs in any cycle where tick_in=1 and its registered copy=0; falling edges are ignored.
REQ-016 SHALL implement states PWR_WAIT, INIT, READY, SETUP, PULSE, HOLD and LINE.
REQ-017 SHALL stay in PWR_WAIT, counting step events, until POWERUP_STEPS events have occurred, then enter INIT.
REQ-018 SHALL, in INIT, issue in order the commands 0x38, 0x0C, 0x06, 0x01 (rs=0), each through the SETUP, PULSE, HOLD sequence, then enter READY.
REQ-019 SHALL drive wr_ready=1 only in READY; busy SHALL equal the inverse of being in READY.
REQ-020 SHALL accept a request when wr_valid=1 and wr_ready=1 (no step event required), latching wr_rs and wr_data, and enter SETUP in the next cycle.
REQ-021 SHALL, in SETUP, drive lcd_rs and lcd_data from the latched values with lcd_e=0.
REQ-022 SHALL move SETUP to PULSE on the next step event, driving lcd_e=1.
REQ-023 SHALL move PULSE to HOLD on the next step event, driving lcd_e=0 with lcd_rs and lcd_data held.
REQ-024 SHALL leave HOLD on the next step event, so a transfer spans exactly 3 step events after acceptance.
REQ-025 SHALL keep a column counter (0..COLS-1) and a line bit (0/1), both 0 after INIT.
REQ-026 SHALL increment the column after each completed data write (rs=1).
REQ-027 SHALL, when the column wraps from COLS-1 to 0, go from HOLD to LINE instead of READY.
REQ-028 SHALL, in LINE, toggle the line bit and issue command 0xC0 (new line 1) or 0x80 (new line 0) through SETUP, PULSE, HOLD, then return to READY.
REQ-029 SHALL, on a completed command 0x01 (clear), reset column and line to 0; no other command affects the cursor.
REQ-030 SHALL ignore wr_valid held while busy; the request is accepted only on the first READY cycle.
REQ-031 SHALL, when a step event coincides with acceptance, not let that event advance SETUP.

Reset
REQ-032 SHALL, with rst=1 at a clk edge, set state PWR_WAIT, all counters 0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, wr_ready=0 and busy=1.
REQ-033 SHALL, on reset in any state including PULSE, deassert lcd_e in the following cycle and abandon any in-progress transfer or insertion.

Verification
REQ-034 SHALL verify power-up: release reset, apply 20 step events, then check four lcd_e pulses carrying 0x38, 0x0C, 0x06, 0x01 with rs=0, then wr_ready=1.
REQ-035 SHALL verify a single write: wr_rs=1, wr_data=0x41 in READY gives busy the next cycle, one lcd_e pulse with lcd_data=0x41, rs=1, and wr_ready=1 after 3 step events.
REQ-036 SHALL verify line wrap: 16 data writes are followed by an automatic 0xC0 command (rs=0) before wr_ready, and 32 data writes are followed by 0x80.
REQ-037 SHALL verify clear: 5 data writes, then 0x01 (rs=0), then 16 data writes produce 0xC0 only after the 16th.
REQ-038 SHALL verify reset mid-pulse: rst=1 while lcd_e=1 gives lcd_e=0, busy=1 the next cycle and a full INIT after 20 steps.
REQ-039 SHALL verify held request: wr_valid=1 held through busy produces exactly one transfer per READY acceptance, and a step event in the acceptance cycle gives no early lcd_e.

Source files
------------

// File: rtl/lcd_sequencer.sv
// HD44780-style LCD write sequencer: power-up wait, init commands, paced SETUP/PULSE/HOLD transfers, auto line wrap.
// A transfer takes 3 step events after acceptance; wr_ready is high only in READY, so requests wait while busy.
module lcd_sequencer #(
  parameter int COLS          = 16,
  parameter int POWERUP_STEPS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW = $clog2(POWERUP_STEPS + 1);

  typedef enum logic [2:0] {PWR_WAIT, INIT, READY, SETUP, PULSE, HOLD, LINE} state_t;
  typedef enum logic [1:0] {SRC_INIT, SRC_USER, SRC_LINE} src_t;

  state_t          state_q, state_d;
  src_t            src_q, src_d;
  logic            tick_q;
  logic [PW-1:0]   pwr_cnt_q, pwr_cnt_d;
  logic [1:0]      init_idx_q, init_idx_d;
  logic [CW-1:0]   col_q, col_d;
  logic            line_q, line_d;
  logic            e_q, e_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            step;

  assign step = tick_in & ~tick_q;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    pwr_cnt_d  = pwr_cnt_q;
    init_idx_d = init_idx_q;
    col_d      = col_q;
    line_d     = line_q;
    e_d        = e_q;
    rs_d       = rs_q;
    data_d     = data_q;
    case (state_q)
      PWR_WAIT: begin
        if (step) begin
          if (pwr_cnt_q == PW'(POWERUP_STEPS - 1)) begin
            pwr_cnt_d  = '0;
            init_idx_d = 2'd0;
            state_d    = INIT;
          end else begin
            pwr_cnt_d = pwr_cnt_q + PW'(1);
          end
        end
      end
      INIT: begin
        rs_d    = 1'b0;
        data_d  = init_cmd(init_idx_q);
        src_d   = SRC_INIT;
        state_d = SETUP;
      end
      READY: begin
        // Acceptance ignores step: a coincident step event cannot reach SETUP yet.
        if (wr_valid) begin
          rs_d    = wr_rs;
          data_d  = wr_data;
          src_d   = SRC_USER;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (step) begin
          e_d     = 1'b1;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (step) begin
          e_d     = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (step) begin
          case (src_q)
            SRC_INIT: begin
              if (init_idx_q == 2'd3) begin
                col_d   = '0;
                line_d  = 1'b0;
                state_d = READY;
              end else begin
                init_idx_d = init_idx_q + 2'd1;
                state_d    = INIT;
              end
            end
            SRC_LINE: state_d = READY;
            default: begin
              state_d = READY;
              if (rs_q) begin
                if (col_q == CW'(COLS - 1)) begin
                  col_d   = '0;
                  state_d = LINE;
                end else begin
                  col_d = col_q + CW'(1);
                end
              end else if (data_q == 8'h01) begin
                col_d  = '0;
                line_d = 1'b0;
              end
            end
          endcase
        end
      end
      LINE: begin
        // line_q still holds the old line: moving to line 1 needs DDRAM address 0x40.
        line_d  = ~line_q;
        rs_d    = 1'b0;
        data_d  = line_q ? 8'h80 : 8'hC0;
        src_d   = SRC_LINE;
        state_d = SETUP;
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PWR_WAIT;
      src_q      <= SRC_INIT;
      tick_q     <= 1'b0;
      pwr_cnt_q  <= '0;
      init_idx_q <= 2'd0;
      col_q      <= '0;
      line_q     <= 1'b0;
      e_q        <= 1'b0;
      rs_q       <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      tick_q     <= tick_in;
      pwr_cnt_q  <= pwr_cnt_d;
      init_idx_q <= init_idx_d;
      col_q      <= col_d;
      line_q     <= line_d;
      e_q        <= e_d;
      rs_q       <= rs_d;
      data_q     <= data_d;
    end
  end

  assign wr_ready = (state_q == READY);
  assign busy     = ~wr_ready;
  assign lcd_e    = e_q;
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;
  assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer: a vector table, hand-written timing sequences and random writes
// checked against a cursor-level model of the LCD pulses each write should produce.
module tb_lcd_sequencer;

  localparam int COLS  = 16;
  localparam int PWR_N = 20;

  logic       clk = 1'b0;
  logic       rst, tick_in, wr_valid, wr_rs;
  logic [7:0] wr_data;
  logic       wr_ready, busy, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;

  int tests = 0;
  int fails = 0;

  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];
  int         m_col, m_line;
  logic       e_prev = 1'b0;

  lcd_sequencer #(.COLS(COLS), .POWERUP_STEPS(PWR_N)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .wr_valid(wr_valid), .wr_rs(wr_rs),
    .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  // Record {rs,data} at every rising edge of the enable strobe.
  always @(negedge clk) begin
    if (lcd_e && !e_prev) obs_q.push_back({lcd_rs, lcd_data});
    e_prev = lcd_e;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step_n(input int n);
    repeat (n) begin
      tick_in = 1'b1;
      cyc(2);
      tick_in = 1'b0;
      cyc(2);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!wr_ready && n < 200) begin
      step_n(1);
      n++;
    end
    chk({name, "_ready"}, 32'(wr_ready), 32'd1);
  endtask

  // Reference: the LCD pulses a write must produce, tracked as a text cursor.
  task automatic m_reset();
    exp_q.delete();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h001);
    m_col  = 0;
    m_line = 0;
  endtask

  task automatic m_write(input logic rs, input logic [7:0] d);
    exp_q.push_back({rs, d});
    if (rs) begin
      m_col++;
      if (m_col == COLS) begin
        m_col  = 0;
        m_line = 1 - m_line;
        exp_q.push_back(m_line == 1 ? 9'h0C0 : 9'h080);
      end
    end else if (d == 8'h01) begin
      m_col  = 0;
      m_line = 0;
    end
  endtask

  task automatic cmp_pulses(input string name);
    int n;
    chk({name, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(name, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_write(input logic rs, input logic [7:0] d);
    wait_ready("wr");
    wr_valid = 1'b1;
    wr_rs    = rs;
    wr_data  = d;
    cyc(1);
    wr_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    m_write(rs, d);
    step_n(3);
  endtask

  task automatic powerup(input string name);
    step_n(PWR_N - 1);
    chk({name, "_wait_busy"}, 32'(busy), 32'd1);
    chk({name, "_wait_quiet"}, obs_q.size(), 0);
    step_n(1 + 11);
    chk({name, "_not_ready_11"}, 32'(wr_ready), 32'd0);
    step_n(1);
    chk({name, "_ready_12"}, 32'(wr_ready), 32'd1);
    cmp_pulses({name, "_cmds"});
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] d;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 8'h01, 9'h001};
    vecs[1] = '{1'b1, 8'h41, 9'h141};
    vecs[2] = '{1'b1, 8'h5A, 9'h15A};
    vecs[3] = '{1'b0, 8'h0C, 9'h00C};
    vecs[4] = '{1'b1, 8'h00, 9'h100};
    vecs[5] = '{1'b1, 8'hFF, 9'h1FF};
    vecs[6] = '{1'b0, 8'h80, 9'h080};
    vecs[7] = '{1'b1, 8'h30, 9'h130};

    rst = 1'b1; tick_in = 1'b0; wr_valid = 1'b0; wr_rs = 1'b0; wr_data = 8'h00;
    cyc(3);
    chk("rst_lcd_e", 32'(lcd_e), 32'd0);
    chk("rst_lcd_rs", 32'(lcd_rs), 32'd0);
    chk("rst_lcd_rw", 32'(lcd_rw), 32'd0);
    chk("rst_lcd_data", 32'(lcd_data), 32'h00);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    m_reset();
    powerup("pwr");

    // Single write with per-step timing.
    wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h41;
    cyc(1);
    wr_valid = 1'b0;
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_setup_e", 32'(lcd_e), 32'd0);
    step_n(1);
    chk("single_pulse_e", 32'(lcd_e), 32'd1);
    chk("single_pulse_data", 32'(lcd_data), 32'h41);
    chk("single_pulse_rs", 32'(lcd_rs), 32'd1);
    chk("single_pulse_rw", 32'(lcd_rw), 32'd0);
    step_n(1);
    chk("single_hold_e", 32'(lcd_e), 32'd0);
    chk("single_hold_data", 32'(lcd_data), 32'h41);
    chk("single_hold_ready", 32'(wr_ready), 32'd0);
    step_n(1);
    chk("single_ready", 32'(wr_ready), 32'd1);
    m_write(1'b1, 8'h41);
    cmp_pulses("single");

    for (int i = 0; i < 8; i++) begin
      do_write(vecs[i].rs, vecs[i].d);
      chk("vec_ready", 32'(wr_ready), 32'd1);
      chk("vec_pulse_count", obs_q.size(), 1);
      if (obs_q.size() > 0) chk("vec_pulse", 32'(obs_q[0]), 32'(vecs[i].exp));
      obs_q.delete();
      exp_q.delete();
    end

    // Line wrap: 16 chars -> 0xC0, 32 chars -> 0x80.
    do_write(1'b0, 8'h01);
    for (int i = 0; i < COLS; i++) do_write(1'b1, 8'h41 + 8'(i));
    chk("wrap_line_busy", 32'(wr_ready), 32'd0);
    wait_ready("wrap16");
    cmp_pulses("wrap16");
    for (int i = 0; i < COLS; i++) do_write(1'b1, 8'h61 + 8'(i));
    wait_ready("wrap32");
    cmp_pulses("wrap32");

    // Clear resets the cursor: wrap only after 16 more chars.
    for (int i = 0; i < 5; i++) do_write(1'b1, 8'h30 + 8'(i));
    do_write(1'b0, 8'h01);
    for (int i = 0; i < COLS - 1; i++) do_write(1'b1, 8'h50);
    chk("clear_no_early_wrap", 32'(wr_ready), 32'd1);
    cmp_pulses("clear15");
    do_write(1'b1, 8'h51);
    wait_ready("clear16");
    cmp_pulses("clear16");

    // Request held through busy: one transfer per READY acceptance.
    do_write(1'b0, 8'h01);
    wait_ready("held_pre");
    cmp_pulses("held_pre");
    wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h55;
    cyc(1);
    step_n(5);
    wr_valid = 1'b0;
    step_n(1);
    cyc(3);
    chk("held_ready", 32'(wr_ready), 32'd1);
    m_write(1'b1, 8'h55);
    m_write(1'b1, 8'h55);
    cmp_pulses("held");

    // Step event in the acceptance cycle must not advance SETUP.
    wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h66; tick_in = 1'b1;
    cyc(1);
    wr_valid = 1'b0;
    chk("coinc_busy", 32'(busy), 32'd1);
    chk("coinc_e0", 32'(lcd_e), 32'd0);
    cyc(2);
    tick_in = 1'b0;
    cyc(2);
    chk("coinc_e_still0", 32'(lcd_e), 32'd0);
    step_n(1);
    chk("coinc_pulse", 32'(lcd_e), 32'd1);
    step_n(2);
    chk("coinc_ready", 32'(wr_ready), 32'd1);
    m_write(1'b1, 8'h66);
    cmp_pulses("coinc");

    // Random writes against the cursor model.
    for (int i = 0; i < 80; i++) begin
      logic       rs;
      logic [7:0] d;
      rs = ($urandom_range(0, 3) != 0);
      if (rs) d = 8'($urandom_range(0, 255));
      else begin
        case ($urandom_range(0, 3))
          0: d = 8'h01;
          1: d = 8'h0C;
          2: d = 8'h06;
          default: d = 8'($urandom_range(0, 255));
        endcase
      end
      do_write(rs, d);
    end
    wait_ready("rand");
    cmp_pulses("rand");

    // Reset while the enable strobe is high.
    wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h77;
    cyc(1);
    wr_valid = 1'b0;
    step_n(1);
    chk("midrst_e_before", 32'(lcd_e), 32'd1);
    rst = 1'b1;
    cyc(1);
    chk("midrst_e", 32'(lcd_e), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    obs_q.delete();
    m_reset();
    powerup("reinit");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
